// File: rtl/local_weight_buffer.sv
// Local weight buffer: burst-written word array with grouped multi-lane reads and a sweep-clear.
// Optional macro WEIGHT_BOUND_CHECK_EN enables the sticky out-of-range flag on err.
module local_weight_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic                    wr_start,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_req,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [1:0]              rd_mode,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    err
);

    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BW    = ADDR_W + 4;
    localparam logic [BW-1:0]     DEPTH_B = BW'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                    state, state_d;
    logic [ADDR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]          clr_cnt;
    logic [DATA_W-1:0]         mem [DEPTH];

    logic                      idle, wr_fire, wr_in_range, wr_ok, rd_accept, clr_done;
    logic [ADDR_W-1:0]         waddr, wr_ptr_nxt;
    logic [BW-1:0]             base;
    logic [BW-1:0]             lane_addr [LANES];
    logic [LANES-1:0]          lane_act;
    logic [LANES*DATA_W-1:0]   lane_data;

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (clear_req) state_d = CLEAR;
            CLEAR:   if (clr_cnt == LAST_C) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign idle        = (state == IDLE);
    assign clr_done    = (state == CLEAR) && (clr_cnt == LAST_C);
    assign wr_fire     = idle && wr_en;
    assign waddr       = wr_start ? wr_addr : wr_ptr;
    assign wr_in_range = (BW'(waddr) < DEPTH_B);
    assign wr_ok       = wr_fire && wr_in_range;
    assign wr_ptr_nxt  = (waddr == LAST_A) ? '0 : waddr + ADDR_W'(1);
    assign rd_accept   = idle && rd_req && (!rd_valid || rd_ready);

    // Lane gather; a same-cycle write to a gathered word is forwarded
    always_comb begin
        case (rd_mode)
            2'd1:    base = BW'(rd_addr) * BW'(3);
            2'd2:    base = BW'(rd_addr) * BW'(LANES);
            default: base = '0;
        endcase
        lane_data = '0;
        lane_act  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_addr[k] = base + BW'(k);
            lane_act[k]  = (rd_mode == 2'd2) || ((rd_mode == 2'd1) && (k < 3));
            if (lane_act[k] && (lane_addr[k] < DEPTH_B)) begin
                if (wr_ok && (BW'(waddr) == lane_addr[k]))
                    lane_data[k*DATA_W +: DATA_W] = wr_data;
                else
                    lane_data[k*DATA_W +: DATA_W] = mem[CNT_W'(lane_addr[k])];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            clr_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= state_d;
            busy  <= (state_d == CLEAR);
            if (state_d == CLEAR)
                wr_ptr <= '0;
            else if (wr_fire)
                wr_ptr <= wr_ptr_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_done ? '0 : clr_cnt + CNT_W'(1);
            else
                clr_cnt <= '0;
            if (rd_accept) begin
                rd_valid <= 1'b1;
                rd_data  <= lane_data;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // Storage array is intentionally not reset
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (wr_ok)
            mem[CNT_W'(waddr)] <= wr_data;
    end

`ifdef WEIGHT_BOUND_CHECK_EN
    logic lane_oob;

    always_comb begin
        lane_oob = 1'b0;
        for (int k = 0; k < LANES; k++)
            if (lane_act[k] && (lane_addr[k] >= DEPTH_B)) lane_oob = 1'b1;
    end

    // Sticky until a clear sweep finishes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (clr_done)
            err <= 1'b0;
        else if ((wr_fire && !wr_in_range) || (rd_accept && lane_oob))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_local_weight_buffer.sv
// Self-checking bench for local_weight_buffer: word-level model feeding a read scoreboard,
// a vector table of grouped reads, and hand-written backpressure/clear/reset sequences.
module tb_local_weight_buffer;

    localparam int DEPTH = 8192;
`ifdef WEIGHT_BOUND_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clear_req = 1'b0;
    logic         busy;
    logic         wr_en = 1'b0;
    logic         wr_start = 1'b0;
    logic [15:0]  wr_addr = '0;
    logic [15:0]  wr_data = '0;
    logic         rd_req = 1'b0;
    logic [15:0]  rd_addr = '0;
    logic [1:0]   rd_mode = '0;
    logic         rd_ready = 1'b1;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         err;

    local_weight_buffer dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
        .wr_en(wr_en), .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_mode(rd_mode), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0]  m_mem [DEPTH];
    logic [127:0] sb [$];
    bit           m_valid = 1'b0;
    bit           m_busy  = 1'b0;
    bit           m_err   = 1'b0;
    int           m_clr   = 0;
    int           m_ptr   = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  mode;
        logic [15:0] first;
        logic [3:0]  n;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input int first, input int n);
        logic [127:0] r = '0;
        for (int k = 0; k < n; k++) r[k*16 +: 16] = 16'(first + k);
        return r;
    endfunction

    function automatic logic [127:0] model_read(input int a, input int mode);
        logic [127:0] r = '0;
        int base = (mode == 1) ? a * 3 : a * 8;
        int n = (mode == 1) ? 3 : (mode == 2) ? 8 : 0;
        for (int k = 0; k < n; k++)
            if (base + k < DEPTH) r[k*16 +: 16] = m_mem[base + k];
        return r;
    endfunction

    function automatic bit model_oob(input int a, input int mode);
        int base = (mode == 1) ? a * 3 : a * 8;
        int n = (mode == 1) ? 3 : (mode == 2) ? 8 : 0;
        return (n > 0) && (base + n - 1 >= DEPTH);
    endfunction

    // One clock: update the model from the driven inputs, then compare the DUT after the edge
    task automatic tick();
        bit acc;
        int wa;
        acc = rd_req && !m_busy && (!m_valid || rd_ready);
        if (wr_en && !m_busy) begin
            wa = wr_start ? int'(wr_addr) : m_ptr;
            if (wa < DEPTH) m_mem[wa] = wr_data;
            else m_err = 1'b1;
            m_ptr = (wa == DEPTH - 1) ? 0 : ((wa + 1) & 16'hFFFF);
        end
        if (m_valid && rd_ready && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            sb.push_back(model_read(int'(rd_addr), int'(rd_mode)));
            if (model_oob(int'(rd_addr), int'(rd_mode))) m_err = 1'b1;
            m_valid = 1'b1;
        end else if (rd_ready) begin
            m_valid = 1'b0;
        end
        if (m_busy) begin
            m_mem[m_clr] = '0;
            m_clr++;
            if (m_clr == DEPTH) begin
                m_busy = 1'b0;
                m_err  = 1'b0;
            end
        end else if (clear_req) begin
            m_busy = 1'b1;
            m_clr  = 0;
            m_ptr  = 0;
        end
        @(posedge clk);
        #1;
        chk("busy", 128'(busy), 128'(m_busy));
        chk("rd_valid", 128'(rd_valid), 128'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) chk("scoreboard_empty", 128'(1), 128'(0));
            else chk("rd_data", rd_data, sb[0]);
        end
        chk("err", 128'(err), 128'(m_err & BCHK));
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_req = 1'b0; clear_req = 1'b0;
        rst = 1'b0;
        m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_clr = 0; m_ptr = 0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_rd_data", rd_data, 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        rst = 1'b1;
    endtask

    task automatic write(input bit start, input int a, input int d);
        wr_en = 1'b1; wr_start = start; wr_addr = 16'(a); wr_data = 16'(d);
        tick();
        wr_en = 1'b0; wr_start = 1'b0;
    endtask

    task automatic read(input int a, input int mode);
        rd_req = 1'b1; rd_addr = 16'(a); rd_mode = 2'(mode);
        tick();
        rd_req = 1'b0;
    endtask

    // Full sweep with reads and writes attempted while busy; counts busy cycles
    task automatic do_clear();
        int n = 0;
        rd_ready = 1'b1;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        while (busy && n < 9000) begin
            rd_req = n[0]; rd_addr = 16'd1023; rd_mode = 2'd2;
            wr_en = (n < 3); wr_start = 1'b1; wr_addr = 16'd5000; wr_data = 16'hDEAD;
            clear_req = (n == 10);
            tick();
            n++;
        end
        rd_req = 1'b0; wr_en = 1'b0; wr_start = 1'b0; clear_req = 1'b0;
        chk("clear_busy_cycles", 128'(n), 128'(DEPTH));
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{addr: 16'd2, mode: 2'd2, first: 16'd17, n: 4'd8};
        tbl[1] = '{addr: 16'd1, mode: 2'd1, first: 16'd4,  n: 4'd3};
        tbl[2] = '{addr: 16'd0, mode: 2'd2, first: 16'd1,  n: 4'd8};
        tbl[3] = '{addr: 16'd7, mode: 2'd1, first: 16'd22, n: 4'd3};
        tbl[4] = '{addr: 16'd3, mode: 2'd2, first: 16'd0,  n: 4'd0};
        tbl[5] = '{addr: 16'd5, mode: 2'd0, first: 16'd0,  n: 4'd0};
        tbl[6] = '{addr: 16'd5, mode: 2'd3, first: 16'd0,  n: 4'd0};
        tbl[7] = '{addr: 16'd8, mode: 2'd1, first: 16'd0,  n: 4'd0};
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        #2;
        do_reset();
        do_clear();

        // Burst fill 0..23 with address+1
        write(1'b1, 0, 1);
        for (int a = 1; a < 24; a++) write(1'b0, 0, a + 1);

        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_req = 1'b1; rd_addr = tbl[i].addr; rd_mode = tbl[i].mode;
            tick();
            chk($sformatf("tbl%0d", i), rd_data, mk(int'(tbl[i].first), int'(tbl[i].n)));
        end
        rd_req = 1'b0;
        tick();

        // Backpressure: data held, pulsed requests not accepted
        rd_ready = 1'b0;
        read(0, 2);
        for (int i = 0; i < 5; i++) begin
            rd_req = (i % 2 == 0); rd_addr = 16'd2; rd_mode = 2'd2;
            tick();
            chk("hold_data", rd_data, mk(1, 8));
        end
        rd_ready = 1'b1;
        read(2, 2);
        chk("after_hold", rd_data, mk(17, 8));
        tick();

        // Same-cycle write and read of word 8
        wr_en = 1'b1; wr_start = 1'b1; wr_addr = 16'd8; wr_data = 16'hBEEF;
        rd_req = 1'b1; rd_addr = 16'd1; rd_mode = 2'd2;
        tick();
        wr_en = 1'b0; wr_start = 1'b0; rd_req = 1'b0;
        chk("wfirst_lane0", 128'(rd_data[15:0]), 128'(16'hBEEF));
        chk("wfirst_lane1", 128'(rd_data[31:16]), 128'(16'd10));

        // Top-of-array burst, then pointer wrap to 0
        write(1'b1, 8184, 16'h3000);
        for (int k = 1; k < 8; k++) write(1'b0, 0, 16'h3000 + k);
        write(1'b0, 0, 16'h2222);
        read(1023, 2);
        chk("top_group", rd_data, mk(16'h3000, 8));
        chk("top_err", 128'(err), 128'(0));
        read(0, 1);
        chk("wrap_word0", 128'(rd_data[47:0]), 128'({16'd3, 16'd2, 16'h2222}));
        read(1024, 2);
        chk("oob_group", rd_data, 128'(0));
        chk("oob_err", 128'(err), 128'(BCHK));
        read(2730, 1);
        chk("edge_group", 128'(rd_data[47:0]), 128'({16'h0, 16'h3007, 16'h3006}));
        tick();

        // Dropped write past the end
        do_reset();
        write(1'b1, 9000, 16'h5555);
        chk("drop_err", 128'(err), 128'(BCHK));
        write(1'b0, 0, 16'h6666);

        // Reset mid-sweep leaves the untouched tail intact
        do_reset();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        do_reset();
        read(0, 2);
        chk("abort_head", rd_data, 128'(0));
        read(1023, 2);
        chk("abort_tail", rd_data, mk(16'h3000, 8));

        // err held through a sweep and released when it completes
        read(1024, 2);
        tick();
        do_clear();
        chk("post_clear_err", 128'(err), 128'(0));
        read(1023, 2);
        chk("post_clear_top", rd_data, 128'(0));
        read(2, 2);
        chk("post_clear_low", rd_data, 128'(0));
        read(625, 2);
        chk("post_clear_ignored_wr", rd_data, 128'(0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
